accumulator_memory: RTL and testbench
=====================================

// Module: accumulator_memory
// PURPOSE
//  Shared operand memory and bus arbiter that feeds NUM_PROC accumulator_processor
//  instances. It holds a pool of operands in a circular FIFO and grants the bus to one
//  processor at a time. It serves FETCH (pop operand) and SEND (push partial sum) transactions.
//  When one value remains and no processor holds data, it flags done and presents the total.
// PARAMETERS
//  NUM_PROC  2   number of processors on the bus
//  DATA_W    32  operand/result width
//  DEPTH     16  operand pool entries (power of 2)
//  ADDR_W    4   log2(DEPTH)
// PORTS
//  clk        in   1                  clock, rising edge
//  reset      in   1                  asynchronous, active-low reset
//  load_valid in   1                  push load_data into pool (LOAD state only)
//  load_data  in   DATA_W             operand to load
//  start      in   1                  end loading, begin accumulation
//  req        in   NUM_PROC           per-processor bus request
//  op         in   2*NUM_PROC         per-processor op, proc i at [2i+1:2i]; 00 NOP, 01 FETCH, 10 SEND
//  write      in   DATA_W*NUM_PROC    per-processor result, proc i at [DATA_W*i +: DATA_W]
//  grant      out  NUM_PROC           one-hot bus grant
//  signal     out  NUM_PROC           one-cycle transaction-complete strobe
//  read       out  DATA_W             operand for FETCH, shared by all processors
//  done       out  1                  accumulation complete (sticky until reset)
//  result     out  DATA_W             final sum, valid while done=1
//  err        out  1                  sticky protocol error / load overflow
// BEHAVIOUR
//  Reset (async, reset=0): all outputs 0; pool empty; phase[i]=0; rr pointer=0; state IDLE.
//  Pool: circular FIFO, head/tail ADDR_W bits wrap mod DEPTH, count ADDR_W+1 bits.
//   FETCH pops at head. SEND and load push at tail.
//  Phase tracking: phase[i] in {0:wantA,1:wantB,2:wantSEND}. Advances 0->1->2->0 on each
//   completed transaction of proc i.
//  Reservation: avail = count - reserved. A phase-0 FETCH needs avail>=2; it pops one and
//   reserves one (reserved+1). A phase-1 FETCH pops the reserved entry (reserved-1).
//   This prevents deadlock where every processor holds an A and none can get a B.
//  Eligible(i) = req[i] && (phase[i]==2 || phase[i]==1 || (phase[i]==0 && avail>=2)).
//  FSM:
//   IDLE    -> LOAD unconditionally next cycle.
//   LOAD    load_valid pushes. Push at count==DEPTH is dropped and sets err.
//           start -> ARB. If start and load_valid coincide, the load is taken first.
//   ARB     if count==1 && reserved==0 && all phase==0: result<=pool[head], done<=1 -> DONE.
//           else pick first eligible i, searching round-robin from rr+1.
//           grant[i]<=1, rr<=i -> XFER. No eligible proc: stay.
//   XFER    sample op of granted proc i:
//           FETCH, expected (phase 0/1): read<=pool[head], pop, signal[i]<=1 -> RELEASE.
//           SEND, expected (phase 2): push write_i, signal[i]<=1 -> RELEASE.
//           NOP: hold grant, stay (no timeout).
//           Op not matching phase: err<=1, no signal, no pool change, phase unchanged -> RELEASE.
//   RELEASE grant<=0, signal<=0, phase[i] advances if signalled -> ARB.
//   DONE    terminal; grant=0, done=1, result held. Only reset exits.
//  Timing per transaction: grant rises 1 cycle after ARB, signal and read valid 1 cycle after
//   op seen. Grant and signal fall together on the next edge. Minimum 3 cycles per transaction.
//  Simultaneous: at most one grant; simultaneous req resolved purely by rr order.
//  start with empty pool: ARB never finishes (no eligible, count!=1). Bench treats this as a hang.
//  start with one value: done the cycle after ARB, result = that value.
//  Overflow impossible after LOAD (each FETCH pair plus SEND nets -1 entry).
//  Reset mid-transaction: grant/signal drop immediately (async), pool discarded.
// TESTING
//  1 NUM_PROC=2, load 1,2,3,4, start, two behavioural processors -> done=1, result=10.
//  2 Both req held high, pool 8 values -> grants alternate proc0/proc1, never both set,
//    signal one cycle per grant.
//  3 Load 2 values (5,7), both procs request -> only one proc fetches A,
//    other not granted until SEND -> result=12, no hang.
//  4 Load single value 0xDEADBEEF, start -> done within 2 cycles, result=0xDEADBEEF,
//    grant never asserted.
//  5 Proc0 drives SEND in phase 0 -> err=1, signal stays 0, count unchanged,
//    grant dropped next cycle.
//  6 Assert reset during XFER with grant=1 -> grant, signal, done, err =0 immediately;
//    rerun of test 1 passes.
//  7 Load 17 values (DEPTH=16) -> err=1, count=16, 17th value absent from final sum.

Source files
------------

// File: rtl/accumulator_memory_if.sv
// Processor-side bus of the accumulator memory: request/op/result in, grant/strobe/operand out.
// Combinational wiring only; flow control is the req/grant/signal handshake.
interface accumulator_memory_if #(
    parameter int NUM_PROC = 2,
    parameter int DATA_W   = 32
);
    logic [NUM_PROC-1:0]        req;
    logic [2*NUM_PROC-1:0]      op;
    logic [DATA_W*NUM_PROC-1:0] write;
    logic [NUM_PROC-1:0]        grant;
    logic [NUM_PROC-1:0]        signal;
    logic [DATA_W-1:0]          read;

    modport master (output req, op, write, input grant, signal, read);
    modport slave  (input req, op, write, output grant, signal, read);
endinterface

// File: rtl/accumulator_memory.sv
// Operand pool plus round-robin bus arbiter feeding accumulator processors; done/result when one value remains.
// Latency: grant 1 cycle after ARB, signal/read 1 cycle after op; a NOP op holds the grant indefinitely.
module accumulator_memory #(
    parameter int NUM_PROC = 2,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    input  logic [DATA_W-1:0]     load_data,
    input  logic                  start,
    accumulator_memory_if.slave   bus,
    output logic                  done,
    output logic [DATA_W-1:0]     result,
    output logic                  err
);
    localparam int IDX_W = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] CNT_TWO  = (ADDR_W+1)'(2);
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [1:0] OP_NOP = 2'b00, OP_FETCH = 2'b01, OP_SEND = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARB, S_XFER, S_RELEASE, S_DONE} state_t;
    state_t state, state_nxt;

    logic [DATA_W-1:0] pool [DEPTH];
    logic [ADDR_W-1:0] head, tail;
    logic [ADDR_W:0]   count, reserved, avail;
    logic [1:0]        phase [NUM_PROC];
    logic [IDX_W-1:0]  rr, gidx, pick_idx;

    logic              found, all_idle;
    logic [NUM_PROC-1:0] eligible;
    logic [1:0]        cur_op, cur_phase;
    logic [DATA_W-1:0] cur_wr, push_dat;
    logic              push, pop, set_err, do_grant, do_sig, finish, res_inc, res_dec;

    always_comb begin
        avail    = count - reserved;
        all_idle = 1'b1;
        for (int i = 0; i < NUM_PROC; i++) begin
            eligible[i] = bus.req[i] && (phase[i] == 2'd2 || phase[i] == 2'd1 ||
                                         (phase[i] == 2'd0 && avail >= CNT_TWO));
            if (phase[i] != 2'd0) all_idle = 1'b0;
        end
        // Round-robin search starts just after the last granted processor.
        found    = 1'b0;
        pick_idx = rr;
        for (int k = 1; k <= NUM_PROC; k++) begin
            int j;
            j = (int'(rr) + k) % NUM_PROC;
            if (!found && eligible[j]) begin
                found    = 1'b1;
                pick_idx = IDX_W'(j);
            end
        end
        cur_op    = bus.op[2*int'(gidx) +: 2];
        cur_wr    = bus.write[DATA_W*int'(gidx) +: DATA_W];
        cur_phase = phase[gidx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_dat  = load_data;
        pop       = 1'b0;
        set_err   = 1'b0;
        do_grant  = 1'b0;
        do_sig    = 1'b0;
        finish    = 1'b0;
        res_inc   = 1'b0;
        res_dec   = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_LOAD;
            S_LOAD: begin
                if (load_valid) begin
                    if (count == CNT_FULL) set_err = 1'b1;
                    else                   push    = 1'b1;
                end
                if (start) state_nxt = S_ARB;
            end
            S_ARB: begin
                if (count == CNT_ONE && reserved == '0 && all_idle) begin
                    finish    = 1'b1;
                    state_nxt = S_DONE;
                end else if (found) begin
                    do_grant  = 1'b1;
                    state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                state_nxt = S_RELEASE;
                if (cur_op == OP_NOP) begin
                    state_nxt = S_XFER;
                end else if (cur_op == OP_FETCH && cur_phase != 2'd2) begin
                    pop     = 1'b1;
                    do_sig  = 1'b1;
                    res_inc = (cur_phase == 2'd0);
                    res_dec = (cur_phase == 2'd1);
                end else if (cur_op == OP_SEND && cur_phase == 2'd2) begin
                    push     = 1'b1;
                    push_dat = cur_wr;
                    do_sig   = 1'b1;
                end else begin
                    set_err = 1'b1;
                end
            end
            S_RELEASE: state_nxt = S_ARB;
            S_DONE:    state_nxt = S_DONE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Pool storage needs no reset: occupancy is tracked by count/head/tail.
    always_ff @(posedge clk) begin
        if (push) pool[tail] <= push_dat;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            reserved   <= '0;
            rr         <= '0;
            gidx       <= '0;
            bus.grant  <= '0;
            bus.signal <= '0;
            bus.read   <= '0;
            done       <= 1'b0;
            result     <= '0;
            err        <= 1'b0;
            for (int i = 0; i < NUM_PROC; i++) phase[i] <= 2'd0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (res_inc)      reserved <= reserved + 1'b1;
            else if (res_dec) reserved <= reserved - 1'b1;
            if (set_err) err <= 1'b1;
            if (finish) begin
                result <= pool[head];
                done   <= 1'b1;
            end
            if (do_grant) begin
                bus.grant <= NUM_PROC'(1) << pick_idx;
                rr        <= pick_idx;
                gidx      <= pick_idx;
            end
            if (pop)    bus.read <= pool[head];
            if (do_sig) bus.signal[gidx] <= 1'b1;
            if (state == S_RELEASE) begin
                bus.grant  <= '0;
                bus.signal <= '0;
                if (bus.signal[gidx])
                    phase[gidx] <= (phase[gidx] == 2'd2) ? 2'd0 : phase[gidx] + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_accumulator_memory.sv
// Self-checking bench: behavioural processors, result scoreboard and bus monitor.
module tb_accumulator_memory;
    localparam int NP = 2;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_valid = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          start = 1'b0;
    logic          done, err;
    logic [DW-1:0] result;

    accumulator_memory_if #(.NUM_PROC(NP), .DATA_W(DW)) bus ();

    accumulator_memory #(.NUM_PROC(NP), .DATA_W(DW), .DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .start(start), .bus(bus), .done(done), .result(result), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] exp_q[$];

    bit             model_en = 1'b0;
    logic [NP-1:0]  man_req = '0;
    logic [2*NP-1:0] man_op = '0;
    logic [1:0]     bph [NP];
    logic [DW-1:0]  ra [NP];
    logic [DW-1:0]  rb [NP];

    int multi_g = 0, any_g = 0, sig_cyc = 0, sig_bad = 0;
    int g_rise [NP];
    int g_order[$];
    logic [NP-1:0] prev_g = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor and behavioural processors share one process so each bus signal has one driver.
    initial begin
        bus.req = '0; bus.op = '0; bus.write = '0;
        for (int i = 0; i < NP; i++) begin
            bph[i] = 2'd0; ra[i] = '0; rb[i] = '0; g_rise[i] = 0;
        end
        forever begin
            @(negedge clk);
            if ($countones(bus.grant) > 1) multi_g++;
            if (bus.grant != '0) any_g++;
            for (int i = 0; i < NP; i++)
                if (bus.grant[i] && !prev_g[i]) begin
                    g_rise[i]++;
                    g_order.push_back(i);
                end
            prev_g = bus.grant;
            if (bus.signal != '0) sig_cyc++;
            if ((bus.signal & ~bus.grant) != '0) sig_bad++;
            if (!reset) begin
                bus.req = '0; bus.op = '0; bus.write = '0;
                for (int i = 0; i < NP; i++) begin
                    bph[i] = 2'd0; ra[i] = '0; rb[i] = '0;
                end
            end else if (model_en) begin
                for (int i = 0; i < NP; i++) begin
                    bus.req[i] = 1'b1;
                    if (bus.signal[i]) begin
                        if (bph[i] == 2'd0) ra[i] = bus.read;
                        if (bph[i] == 2'd1) rb[i] = bus.read;
                        bph[i] = (bph[i] == 2'd2) ? 2'd0 : bph[i] + 2'd1;
                        bus.op[2*i +: 2] = 2'b00;
                    end else if (bus.grant[i]) begin
                        bus.op[2*i +: 2] = (bph[i] == 2'd2) ? 2'b10 : 2'b01;
                        bus.write[DW*i +: DW] = ra[i] + rb[i];
                    end else begin
                        bus.op[2*i +: 2] = 2'b00;
                    end
                end
            end else begin
                bus.req = man_req; bus.op = man_op; bus.write = '0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        model_en = 1'b0; man_req = '0; man_op = '0;
        load_valid = 1'b0; start = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic load(input logic [DW-1:0] v);
        load_valid = 1'b1; load_data = v;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic go();
        model_en = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        logic [DW-1:0] e;
        for (n = 0; n < 3000 && !done; n++) @(negedge clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        if (!done) chk({tag, "_timeout"}, 0, 1);
        else       chk(tag, result, e);
    endtask

    task automatic run_sum4(input string tag);
        do_reset();
        for (int v = 1; v <= 4; v++) load(DW'(v));
        exp_q.push_back(32'd10);
        go();
        wait_done({tag, "_result"});
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        int base, bm, bs, bg, bb, b0, b1, ba, cyc;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_grant", bus.grant, 0);
        chk("rst_signal", bus.signal, 0);
        chk("rst_read", bus.read, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_err", err, 0);

        run_sum4("t1");

        // Alternating grants with both processors always requesting.
        do_reset();
        base = g_order.size(); bm = multi_g; bs = sig_cyc; bb = sig_bad;
        bg = g_rise[0] + g_rise[1];
        for (int v = 1; v <= 8; v++) load(DW'(v));
        exp_q.push_back(32'd36);
        go();
        wait_done("t2_result");
        chk("t2_onehot", multi_g - bm, 0);
        chk("t2_sig_per_grant", sig_cyc - bs, g_rise[0] + g_rise[1] - bg);
        chk("t2_sig_on_grant", sig_bad - bb, 0);
        chk("t2_order_len", (g_order.size() - base) >= 6, 1);
        if ((g_order.size() - base) >= 6)
            for (int k = 0; k < 6; k++) chk("t2_order", g_order[base+k], (k % 2 == 0) ? 1 : 0);

        // Two operands: reservation keeps proc0 off the bus entirely.
        do_reset();
        b0 = g_rise[0]; b1 = g_rise[1];
        load(32'd5); load(32'd7);
        exp_q.push_back(32'd12);
        go();
        wait_done("t3_result");
        chk("t3_p0_grants", g_rise[0] - b0, 0);
        chk("t3_p1_grants", g_rise[1] - b1, 3);

        // Single operand finishes straight from ARB.
        do_reset();
        ba = any_g;
        load(32'hDEAD_BEEF);
        exp_q.push_back(32'hDEAD_BEEF);
        model_en = 1'b1; start = 1'b1;
        cyc = 0;
        for (int n = 0; n < 10 && !done; n++) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        chk("t4_latency", cyc, 2);
        wait_done("t4_result");
        chk("t4_no_grant", any_g - ba, 0);

        // Proc0 sends while still in phase 0.
        do_reset();
        load(32'd1); load(32'd2); load(32'd3);
        man_op = 4'b0010; man_req = 2'b01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 50 && !bus.grant[0]; n++) @(negedge clk);
        chk("t5_grant", bus.grant[0], 1);
        @(negedge clk);
        chk("t5_err", err, 1);
        chk("t5_signal", bus.signal, 0);
        chk("t5_count", 32'(dut.count), 3);
        @(negedge clk);
        chk("t5_grant_drop", bus.grant, 0);

        // Reset in the middle of a transaction, then a clean rerun.
        do_reset();
        for (int v = 1; v <= 4; v++) load(DW'(v));
        go();
        for (int n = 0; n < 50 && bus.grant == '0; n++) @(negedge clk);
        chk("t6_grant_seen", |bus.grant, 1);
        reset = 1'b0;
        #1;
        chk("t6_grant", bus.grant, 0);
        chk("t6_signal", bus.signal, 0);
        chk("t6_done", done, 0);
        chk("t6_err", err, 0);
        run_sum4("t6_rerun");

        // Overflow: 17th load dropped.
        do_reset();
        for (int v = 1; v <= 17; v++) load(DW'(v));
        chk("t7_err", err, 1);
        chk("t7_count", 32'(dut.count), 16);
        exp_q.push_back(32'd136);
        go();
        wait_done("t7_result");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
